// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and USB HID key codes for game_flow_ctrl
package game_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_ROAM   = 2'd1,
        ST_BATTLE = 2'd2,
        ST_END    = 2'd3
    } game_state_e;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - turns a level keycode into one event per new non-zero key
module key_edge
    import game_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode_i,
    output logic       key_evt_o,
    output logic [7:0] key_code_o
);

    logic [7:0] key_prev_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_prev_q <= 8'h00;
        end else begin
            key_prev_q <= keycode_i;
        end
    end

    // A held key matches key_prev after its first cycle, so it fires only once.
    assign key_evt_o  = (keycode_i != 8'h00) && (keycode_i != key_prev_q);
    assign key_code_o = keycode_i;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - start/roam/battle/end flow with team selection grid
// Optional BKSP undo of the last pick when GAME_FLOW_UNDO_EN is defined.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int GRID_COLS = 4,
    parameter int GRID_ROWS = 2,
    parameter int TEAM_SIZE = 3,
    localparam int ID_W  = $clog2(GRID_COLS * GRID_ROWS),
    localparam int CNT_W = $clog2(TEAM_SIZE + 1)
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [7:0]                     keycode,
    input  logic                           start_battle,
    input  logic                           end_battle,
    input  logic                           result,
    output logic [1:0]                     state_o,
    output logic                           is_start,
    output logic                           is_roam,
    output logic                           is_battle,
    output logic                           is_end,
    output logic [ID_W-1:0]                cursor,
    output logic [TEAM_SIZE-1:0][ID_W-1:0] team,
    output logic [CNT_W-1:0]               num_chosen,
    output logic                           team_full,
    output logic                           pick_reject
);

    game_state_e                   state_q, state_d;
    logic [ID_W-1:0]               cursor_q, cursor_d;
    logic [TEAM_SIZE-1:0][ID_W-1:0] team_q, team_d;
    logic [CNT_W-1:0]              num_q, num_d;
    logic                          reject_q, reject_d;

    logic       key_evt;
    logic [7:0] key_code;
    logic       full;
    logic       dup;
    int         row, col;

    key_edge u_key_edge (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode_i  (keycode),
        .key_evt_o  (key_evt),
        .key_code_o (key_code)
    );

    assign full = (num_q == CNT_W'(TEAM_SIZE));

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < TEAM_SIZE; i++) begin
            if ((i < int'(num_q)) && (team_q[i] == cursor_q)) begin
                dup = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_START;
            cursor_q <= '0;
            team_q   <= '0;
            num_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            team_q   <= team_d;
            num_q    <= num_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        team_d   = team_q;
        num_d    = num_q;
        reject_d = 1'b0;
        row      = int'(cursor_q) / GRID_COLS;
        col      = int'(cursor_q) % GRID_COLS;

        unique case (state_q)
            ST_START: begin
                if (key_evt) begin
                    case (key_code)
                        KEY_W: row = (row == 0) ? GRID_ROWS - 1 : row - 1;
                        KEY_S: row = (row == GRID_ROWS - 1) ? 0 : row + 1;
                        KEY_A: col = (col == 0) ? GRID_COLS - 1 : col - 1;
                        KEY_D: col = (col == GRID_COLS - 1) ? 0 : col + 1;
                        KEY_ENTER: begin
                            if (full) begin
                                state_d = ST_ROAM;
                            end else if (dup) begin
                                reject_d = 1'b1;
                            end else begin
                                for (int i = 0; i < TEAM_SIZE; i++) begin
                                    if (i == int'(num_q)) team_d[i] = cursor_q;
                                end
                                num_d = num_q + 1'b1;
                            end
                        end
`ifdef GAME_FLOW_UNDO_EN
                        KEY_BKSP: begin
                            if (num_q == '0) begin
                                reject_d = 1'b1;
                            end else begin
                                for (int i = 0; i < TEAM_SIZE; i++) begin
                                    if (i == int'(num_q) - 1) team_d[i] = '0;
                                end
                                num_d = num_q - 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                    cursor_d = ID_W'(row * GRID_COLS + col);
                end
            end
            ST_ROAM: begin
                if (start_battle) state_d = ST_BATTLE;
            end
            ST_BATTLE: begin
                if (end_battle) state_d = result ? ST_ROAM : ST_END;
            end
            ST_END: begin
                if (key_evt) begin
                    state_d  = ST_START;
                    cursor_d = '0;
                    team_d   = '0;
                    num_d    = '0;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    assign state_o     = state_q;
    assign is_start    = (state_q == ST_START);
    assign is_roam     = (state_q == ST_ROAM);
    assign is_battle   = (state_q == ST_BATTLE);
    assign is_end      = (state_q == ST_END);
    assign cursor      = cursor_q;
    assign team        = team_q;
    assign num_chosen  = num_q;
    assign team_full   = full;
    assign pick_reject = reject_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [7:0]       keycode;
    logic             start_battle;
    logic             end_battle;
    logic             result;
    logic [1:0]       state_o;
    logic             is_start, is_roam, is_battle, is_end;
    logic [2:0]       cursor;
    logic [2:0][2:0]  team;
    logic [1:0]       num_chosen;
    logic             team_full;
    logic             pick_reject;

    int checks = 0;
    int errors = 0;
    int rej_cnt;

    game_flow_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .start_battle (start_battle),
        .end_battle   (end_battle),
        .result       (result),
        .state_o      (state_o),
        .is_start     (is_start),
        .is_roam      (is_roam),
        .is_battle    (is_battle),
        .is_end       (is_end),
        .cursor       (cursor),
        .team         (team),
        .num_chosen   (num_chosen),
        .team_full    (team_full),
        .pick_reject  (pick_reject)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] code);
        keycode = code;
        tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_is_start"}, int'({is_start, is_roam, is_battle, is_end}), 8);
        check({tag, "_cursor"}, int'(cursor), 0);
        check({tag, "_team"}, int'(team), 0);
        check({tag, "_num"}, int'(num_chosen), 0);
        check({tag, "_full"}, int'(team_full), 0);
        check({tag, "_rej"}, int'(pick_reject), 0);
    endtask

    task automatic fill_123();
        press(8'h07); press(8'h28);
        press(8'h07); press(8'h28);
        press(8'h07); press(8'h28);
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; start_battle = 1'b0;
        end_battle = 1'b0; result = 1'b0;
        do_reset();
        check_reset_state("rst");

        press(8'h07); check("d1", int'(cursor), 1);
        press(8'h07); check("d2", int'(cursor), 2);
        press(8'h07); check("d3", int'(cursor), 3);
        press(8'h07); check("d4_wrap", int'(cursor), 0);
        press(8'h07); press(8'h07);
        press(8'h1A); check("w_wrap", int'(cursor), 6);
        press(8'h16); check("s_wrap", int'(cursor), 2);
        press(8'h10); check("unlisted_key", int'(cursor), 2);
        press(8'h16); press(8'h04);
        check("a_to5", int'(cursor), 5);

        // Held ENTER: exactly one pick.
        keycode = 8'h28;
        rej_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rej_cnt += int'(pick_reject);
        end
        keycode = 8'h00;
        tick();
        check("hold_num", int'(num_chosen), 1);
        check("hold_team0", int'(team[0]), 5);
        check("hold_norej", rej_cnt, 0);

        keycode = 8'h28;
        tick();
        check("dup_rej_hi", int'(pick_reject), 1);
        keycode = 8'h00;
        tick();
        check("dup_rej_lo", int'(pick_reject), 0);
        check("dup_num", int'(num_chosen), 1);
        check("dup_team1", int'(team[1]), 0);

`ifndef GAME_FLOW_UNDO_EN
        press(8'h2A);
        check("bksp_ignored", int'(num_chosen), 1);
`endif

        do_reset();
        fill_123();
        check("fill_num", int'(num_chosen), 3);
        check("fill_full", int'(team_full), 1);
        check("fill_team", int'(team), (3 << 6) | (2 << 3) | 1);
        keycode = 8'h28;
        tick();
        check("to_roam", int'(state_o), 1);
        check("to_roam_rej", int'(pick_reject), 0);
        keycode = 8'h00;
        tick();
        press(8'h07);
        check("roam_cursor", int'(cursor), 3);
        start_battle = 1'b1; tick(); start_battle = 1'b0;
        check("to_battle", int'({is_start, is_roam, is_battle, is_end}), 2);
        start_battle = 1'b1; tick(); start_battle = 1'b0;
        check("battle_ignore_sb", int'(state_o), 2);
        end_battle = 1'b1; result = 1'b0; tick(); end_battle = 1'b0;
        check("to_end", int'(state_o), 3);
        press(8'h10);
        check("end_to_start", int'(state_o), 0);
        check("end_num", int'(num_chosen), 0);
        check("end_team", int'(team), 0);
        check("end_cursor", int'(cursor), 0);

        fill_123();
        press(8'h28);
        start_battle = 1'b1; tick(); start_battle = 1'b0;
        end_battle = 1'b1; result = 1'b1; tick(); end_battle = 1'b0;
        check("win_roam", int'(state_o), 1);
        start_battle = 1'b1; tick(); start_battle = 1'b0;
        check("battle2", int'(state_o), 2);
        end_battle = 1'b1; result = 1'b1; Reset = 1'b1;
        tick();
        end_battle = 1'b0; result = 1'b0; Reset = 1'b0;
        check_reset_state("mid_rst");

`ifdef GAME_FLOW_UNDO_EN
        press(8'h16); press(8'h28);
        press(8'h04); press(8'h28);
        check("undo_pre_num", int'(num_chosen), 2);
        check("undo_pre_t1", int'(team[1]), 7);
        press(8'h2A);
        check("undo_num", int'(num_chosen), 1);
        check("undo_t1", int'(team[1]), 0);
        check("undo_t0", int'(team[0]), 4);
        press(8'h2A);
        check("undo_num0", int'(num_chosen), 0);
        keycode = 8'h2A;
        tick();
        check("undo_rej", int'(pick_reject), 1);
        keycode = 8'h00;
        tick();
        check("undo_rej_lo", int'(pick_reject), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
